mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage sitting directly downstream of the execute stage, between the EX/MEM and MEM/WB pipeline registers. It takes the ALU result as an effective address, plus the forwarded rs2 value as store data. It runs a request/response handshake with the data memory and aligns and extends load data. It raises a misalignment trap and produces the registered MEM/WB outputs. It stalls the upstream pipeline while a memory transaction is outstanding.

## Interface
Parameters: none.

Clock and reset: one clock (`i_clk`); reset (`i_rst`) is asynchronous and active-high.

- i_clk  in  1  clock
- i_rst  in  1  asynchronous, active-high reset
- i_valid  in  1  EX/MEM holds a live instruction
- i_addr  in  32  ALU result from execute; effective address, or pass-through data for non-memory ops
- i_store_data  in  32  forwarded rs2 value
- i_is_load  in  1  instruction is a load
- i_is_store  in  1  instruction is a store
- i_size  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal
- i_unsigned  in  1  zero-extend load (LBU/LHU)
- i_reg_write_en  in  1  instruction writes rd
- i_dest_addr  in  5  rd
- o_stall  out  1  hold EX/MEM and all upstream stages this cycle
- o_dmem_req  out  1  memory request valid
- o_dmem_we  out  1  request is a write
- o_dmem_addr  out  32  word address, {addr[31:2],2'b00}
- o_dmem_wdata  out  32  lane-replicated store data
- o_dmem_mask  out  4  byte-lane write enables
- i_dmem_ready  in  1  memory accepts request this cycle
- i_dmem_rvalid  in  1  load response valid
- i_dmem_rdata  in  32  load response word
- o_wb_valid  out  1  MEM/WB holds a retired instruction
- o_wb_data  out  32  load result or pass-through ALU result
- o_wb_reg_write_en  out  1  write rd
- o_wb_dest_addr  out  5  rd
- o_wb_trap  out  1  misaligned or illegal-size access

## Operation
- FSM states: IDLE, REQ, WAIT.
- **Misaligned** means any of: half with addr[0]=1; word with addr[1:0]≠0; size 11.
- **start** = IDLE & i_valid & (i_is_load | i_is_store) & !misaligned.
- **IDLE:**
  - On start: capture addr, size, unsigned, store data, dest, reg_write_en, load/store into internal registers; go to REQ.
  - Otherwise, register i_* into o_wb_* at the clock edge: o_wb_valid=i_valid, o_wb_data=i_addr.
  - Misaligned memory op: o_wb_trap=1, o_wb_reg_write_en=0, no request issued.
- **REQ:**
  - o_dmem_req=1; request fields come from the captured registers and stay stable until accepted.
  - On i_dmem_ready: a store completes (o_wb_valid=1, reg_write_en=0) and goes to IDLE; a load goes to WAIT.
- **WAIT:**
  - On i_dmem_rvalid: o_wb_data = extracted lane, sign- or zero-extended; o_wb_valid=1; go to IDLE.
- **o_stall** (combinational) = start | (REQ & !(store & i_dmem_ready)) | (WAIT & !i_dmem_rvalid).
  - Stall is low in the completion cycle, so EX/MEM advances at that edge.
  - The held instruction is never restarted, because the FSM is not in IDLE during that cycle.
- **o_wb_valid**: 0 on every cycle that does not retire an instruction, including bubbles during stalls.
- **Store lanes:**
  - byte: wdata={4{d[7:0]}}, mask=4'b0001<<addr[1:0].
  - half: wdata={2{d[15:0]}}, mask=addr[1] ? 1100 : 0011.
  - word: wdata=d, mask=1111.
- **Load extraction:**
  - byte: rdata[8*addr[1:0] +: 8].
  - half: rdata[16*addr[1] +: 16].
  - Extension: i_unsigned selects zero-extend, otherwise sign-extend.
- **Idle memory outputs**: o_dmem_we/addr/wdata/mask are 0 whenever o_dmem_req=0.
- **Ignored memory signals**:
  - i_dmem_rvalid is ignored in IDLE and REQ.
  - i_dmem_ready is ignored outside REQ.
- **Writes to x0**: rd=0 with reg_write_en=1 passes through unchanged; masking is the register file's responsibility.

## Timing
- **Reset**: all registered outputs are 0 and state is IDLE; o_stall=0 and o_dmem_req=0 while i_rst is high.
- **Reset mid-transaction**: asynchronous return to IDLE; o_dmem_req drops immediately; any pending response is discarded.
- **Non-memory op and trap**: o_wb_* valid one cycle after presentation.
- **Load, best case** (ready in first REQ cycle, rvalid the next cycle):
  - stall high in cycles 0–1, low in cycle 2;
  - o_wb_valid high in cycle 3.
- **Store, best case**:
  - stall high in cycle 0, low in cycle 1 (ready);
  - o_wb_valid high in cycle 2.
- **Wait states**: each cycle without i_dmem_ready in REQ, or without i_dmem_rvalid in WAIT, adds one cycle of stall and delays o_wb_valid by one cycle.
- **Back-to-back memory ops**: the next instruction is presented in the cycle after completion, so start can fire in the cycle after completion; the throughput is therefore at most one memory op per 2 cycles.

## Test plan
- **Signed byte load**: LB, addr=0x1003, i_dmem_rdata=0x80FF_1234, ready and rvalid immediate -> o_dmem_addr=0x1000; o_wb_data=0xFFFF_FF80 in cycle 3; stall high cycles 0–1.
- **Unsigned half load with wait states**: LHU, addr=0x2002, rdata=0xBEEF_0000, ready delayed 2 cycles, rvalid delayed 3 cycles -> o_wb_data=0x0000_BEEF; stall held throughout; o_dmem_req stable while waiting.
- **Store byte**: SB, addr=0x3001, data=0x0000_00A5 -> mask=0010, wdata=0xA5A5_A5A5, we=1; o_wb_valid=1 with reg_write_en=0 two cycles later.
- **Misaligned word load**: LW, addr=0x4002 -> no o_dmem_req; next cycle o_wb_valid=1, o_wb_trap=1, reg_write_en=0; o_stall never asserted.
- **ALU pass-through, then load**: ADD (i_addr=0x1234, rd=5) followed by a load -> o_wb_data=0x1234 with rd=5 one cycle after presentation; the load then starts with no lost or duplicated retirement.
- **Reset during WAIT**: assert i_rst during WAIT, then assert rvalid -> all outputs 0 immediately; the response is ignored; the FSM is IDLE on release.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: drives a req/ready/rvalid data-memory handshake,
// aligns store lanes and load data, flags misaligned accesses, registers MEM/WB.
module mem_stage (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_store_data,
    input  logic        i_is_load,
    input  logic        i_is_store,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic        i_reg_write_en,
    input  logic [4:0]  i_dest_addr,
    output logic        o_stall,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_mask,
    input  logic        i_dmem_ready,
    input  logic        i_dmem_rvalid,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_wb_valid,
    output logic [31:0] o_wb_data,
    output logic        o_wb_reg_write_en,
    output logic [4:0]  o_wb_dest_addr,
    output logic        o_wb_trap
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t      state;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_mask;
    logic [1:0]  cap_size;
    logic        cap_unsigned;
    logic        cap_is_store;
    logic        cap_reg_write_en;
    logic [4:0]  cap_dest;

    logic mem_op;
    logic misaligned;
    logic start;
    logic req;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return lo[0];
            2'b10:   return (lo != 2'b00);
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] d);
        case (size)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'b00:   return 4'b0001 << lo;
            2'b01:   return lo[1] ? 4'b1100 : 4'b0011;
            2'b10:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [1:0] size, input logic [1:0] lo,
                                                 input logic uns, input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[{lo, 3'b000} +: 8];
        h = rdata[{lo[1], 4'b0000} +: 16];
        case (size)
            2'b00:   return uns ? {24'h0, b} : {{24{b[7]}}, b};
            2'b01:   return uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: return rdata;
        endcase
    endfunction

    assign mem_op     = i_is_load | i_is_store;
    assign misaligned = is_misaligned(i_size, i_addr[1:0]);
    assign start      = (state == IDLE) & i_valid & mem_op & !misaligned;
    assign req        = (state == REQ) & !i_rst;

    // Stall drops in the completion cycle so EX/MEM advances on that edge.
    always_comb begin
        o_stall = 1'b0;
        if (!i_rst) begin
            o_stall = start
                    | ((state == REQ) & !(cap_is_store & i_dmem_ready))
                    | ((state == WAIT) & !i_dmem_rvalid);
        end
    end

    always_comb begin
        o_dmem_req   = req;
        o_dmem_we    = req & cap_is_store;
        o_dmem_addr  = req ? {cap_addr[31:2], 2'b00} : 32'h0;
        o_dmem_wdata = req ? cap_wdata : 32'h0;
        o_dmem_mask  = req ? cap_mask : 4'h0;
    end

    // Captured request fields hold steady for the whole transaction.
    always_ff @(posedge i_clk) begin
        if (start) begin
            cap_addr         <= i_addr;
            cap_size         <= i_size;
            cap_unsigned     <= i_unsigned;
            cap_is_store     <= i_is_store;
            cap_reg_write_en <= i_reg_write_en;
            cap_dest         <= i_dest_addr;
            cap_wdata        <= i_is_store ? lane_wdata(i_size, i_store_data) : 32'h0;
            cap_mask         <= i_is_store ? lane_mask(i_size, i_addr[1:0]) : 4'h0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state             <= IDLE;
            o_wb_valid        <= 1'b0;
            o_wb_data         <= 32'h0;
            o_wb_reg_write_en <= 1'b0;
            o_wb_dest_addr    <= 5'h0;
            o_wb_trap         <= 1'b0;
        end else begin
            o_wb_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= REQ;
                    end else begin
                        o_wb_valid        <= i_valid;
                        o_wb_data         <= i_addr;
                        o_wb_dest_addr    <= i_dest_addr;
                        o_wb_trap         <= i_valid & mem_op & misaligned;
                        o_wb_reg_write_en <= i_valid & i_reg_write_en & !(mem_op & misaligned);
                    end
                end
                REQ: begin
                    if (i_dmem_ready) begin
                        if (cap_is_store) begin
                            state             <= IDLE;
                            o_wb_valid        <= 1'b1;
                            o_wb_data         <= cap_addr;
                            o_wb_reg_write_en <= 1'b0;
                            o_wb_dest_addr    <= cap_dest;
                            o_wb_trap         <= 1'b0;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (i_dmem_rvalid) begin
                        state             <= IDLE;
                        o_wb_valid        <= 1'b1;
                        o_wb_data         <= load_extract(cap_size, cap_addr[1:0], cap_unsigned, i_dmem_rdata);
                        o_wb_reg_write_en <= cap_reg_write_en;
                        o_wb_dest_addr    <= cap_dest;
                        o_wb_trap         <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, reset corner sequences and
// randomized back-to-back ops checked against an arithmetic reference model.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic [31:0] i_addr;
    logic [31:0] i_store_data;
    logic        i_is_load;
    logic        i_is_store;
    logic [1:0]  i_size;
    logic        i_unsigned;
    logic        i_reg_write_en;
    logic [4:0]  i_dest_addr;
    logic        o_stall;
    logic        o_dmem_req;
    logic        o_dmem_we;
    logic [31:0] o_dmem_addr;
    logic [31:0] o_dmem_wdata;
    logic [3:0]  o_dmem_mask;
    logic        i_dmem_ready;
    logic        i_dmem_rvalid;
    logic [31:0] i_dmem_rdata;
    logic        o_wb_valid;
    logic [31:0] o_wb_data;
    logic        o_wb_reg_write_en;
    logic [4:0]  o_wb_dest_addr;
    logic        o_wb_trap;

    int checks = 0;
    int errors = 0;

    mem_stage dut (
        .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_addr(i_addr),
        .i_store_data(i_store_data), .i_is_load(i_is_load), .i_is_store(i_is_store),
        .i_size(i_size), .i_unsigned(i_unsigned), .i_reg_write_en(i_reg_write_en),
        .i_dest_addr(i_dest_addr), .o_stall(o_stall), .o_dmem_req(o_dmem_req),
        .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr), .o_dmem_wdata(o_dmem_wdata),
        .o_dmem_mask(o_dmem_mask), .i_dmem_ready(i_dmem_ready), .i_dmem_rvalid(i_dmem_rvalid),
        .i_dmem_rdata(i_dmem_rdata), .o_wb_valid(o_wb_valid), .o_wb_data(o_wb_data),
        .o_wb_reg_write_en(o_wb_reg_write_en), .o_wb_dest_addr(o_wb_dest_addr),
        .o_wb_trap(o_wb_trap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] addr;
        logic [31:0] data;
        logic        ld;
        logic        st;
        logic [1:0]  size;
        logic        uns;
        logic        rwe;
        logic [4:0]  dest;
        int          rd;
        int          rv;
        logic [31:0] rdata;
        logic [31:0] exp_data;
        logic        exp_trap;
        logic [3:0]  exp_mask;
        logic [31:0] exp_wdata;
    } op_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic op_t mk(input logic v, input logic [31:0] a, input logic [31:0] d,
                               input logic ld, input logic st, input logic [1:0] sz,
                               input logic u, input logic w, input logic [4:0] rd_addr,
                               input int rdly, input int rvdly, input logic [31:0] rdat,
                               input logic [31:0] ed, input logic et, input logic [3:0] em,
                               input logic [31:0] ew);
        op_t o;
        o.valid = v; o.addr = a; o.data = d; o.ld = ld; o.st = st; o.size = sz;
        o.uns = u; o.rwe = w; o.dest = rd_addr; o.rd = rdly; o.rv = rvdly; o.rdata = rdat;
        o.exp_data = ed; o.exp_trap = et; o.exp_mask = em; o.exp_wdata = ew;
        return o;
    endfunction

    // Reference: byte-count arithmetic on the access, independent of lane encodings.
    function automatic op_t model(input op_t o);
        int     nb;
        int     off;
        longint v;
        nb  = (o.size == 2'd0) ? 1 : (o.size == 2'd1) ? 2 : 4;
        off = int'(o.addr[1:0]);
        o.exp_trap  = o.valid && (o.ld || o.st) && (o.size == 2'd3 || (off % nb) != 0);
        o.exp_data  = o.addr;
        o.exp_mask  = 4'h0;
        o.exp_wdata = 32'h0;
        if (o.ld && !o.exp_trap) begin
            v = (longint'(o.rdata) >> (8 * off)) & ((longint'(1) << (8 * nb)) - 1);
            if (!o.uns && v >= (longint'(1) << (8 * nb - 1)))
                v = v - (longint'(1) << (8 * nb));
            o.exp_data = v[31:0];
        end
        if (o.st) begin
            for (int b = 0; b < 4; b++) begin
                if (b >= off && b < off + nb) o.exp_mask[b] = 1'b1;
                o.exp_wdata[8*b +: 8] = o.data[8*(b % nb) +: 8];
            end
        end
        return o;
    endfunction

    // Presents one op at posedge+1, plays the memory side, returns at posedge+1
    // after the completion edge with MEM/WB checked.
    task automatic run_op(input op_t op, input string tag);
        int cyc, stalls, reqs, waitc, req_bad, idle_bad, dup, exp_st;
        bit done, accepted, mem_ok;
        mem_ok = op.valid && (op.ld || op.st) && !op.exp_trap;
        i_valid = op.valid; i_addr = op.addr; i_store_data = op.data;
        i_is_load = op.ld; i_is_store = op.st; i_size = op.size; i_unsigned = op.uns;
        i_reg_write_en = op.rwe; i_dest_addr = op.dest; i_dmem_rdata = op.rdata;
        cyc = 0; stalls = 0; reqs = 0; waitc = 0; req_bad = 0; idle_bad = 0; dup = 0;
        done = 0; accepted = 0;
        while (!done && cyc < 40) begin
            i_dmem_ready = 1'b0;
            i_dmem_rvalid = 1'b0;
            if (o_dmem_req) i_dmem_ready = (reqs == op.rd);
            else if (accepted) begin
                i_dmem_rvalid = (waitc == op.rv);
                waitc++;
            end else if (!mem_ok) i_dmem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (o_dmem_req) begin
                reqs++;
                if (o_dmem_addr !== {op.addr[31:2], 2'b00} || o_dmem_we !== op.st) req_bad++;
                if (op.st && (o_dmem_mask !== op.exp_mask || o_dmem_wdata !== op.exp_wdata)) req_bad++;
                if (i_dmem_ready && op.ld) accepted = 1;
            end else if ({o_dmem_we, o_dmem_addr, o_dmem_wdata, o_dmem_mask} !== 69'h0) begin
                idle_bad++;
            end
            if (o_stall === 1'b1) stalls++;
            if (cyc > 0 && o_wb_valid !== 1'b0) dup++;
            if (o_stall !== 1'b1) done = 1;
            @(posedge clk); #1;
            cyc++;
        end
        exp_st = !mem_ok ? 0 : (op.st ? 1 + op.rd : 2 + op.rd + op.rv);
        chk({tag, " completed"}, 32'(done), 32'd1);
        chk({tag, " stall_cycles"}, 32'(stalls), 32'(exp_st));
        chk({tag, " req_cycles"}, 32'(reqs), mem_ok ? 32'(op.rd + 1) : 32'd0);
        chk({tag, " req_fields_bad"}, 32'(req_bad), 32'd0);
        chk({tag, " idle_mem_outputs_bad"}, 32'(idle_bad), 32'd0);
        chk({tag, " early_wb_valid"}, 32'(dup), 32'd0);
        chk({tag, " wb_valid"}, 32'(o_wb_valid), 32'(op.valid));
        if (op.valid) begin
            chk({tag, " wb_trap"}, 32'(o_wb_trap), 32'(op.exp_trap));
            chk({tag, " wb_rwe"}, 32'(o_wb_reg_write_en),
                (op.exp_trap || op.st) ? 32'd0 : 32'(op.rwe));
            chk({tag, " wb_dest"}, 32'(o_wb_dest_addr), 32'(op.dest));
            if (!op.st) chk({tag, " wb_data"}, o_wb_data, op.exp_data);
        end
        i_valid = 1'b0; i_is_load = 1'b0; i_is_store = 1'b0;
        i_dmem_ready = 1'b0; i_dmem_rvalid = 1'b0;
    endtask

    op_t tbl[15];
    op_t r;

    initial begin
        tbl[0]  = mk(1, 32'h1003, 32'h0,        1, 0, 2'd0, 0, 1, 5'd1,  0, 0, 32'h80FF1234, 32'hFFFFFF80, 0, 4'h0,    32'h0);
        tbl[1]  = mk(1, 32'h2002, 32'h0,        1, 0, 2'd1, 1, 1, 5'd2,  2, 3, 32'hBEEF0000, 32'h0000BEEF, 0, 4'h0,    32'h0);
        tbl[2]  = mk(1, 32'h3001, 32'hA5,       0, 1, 2'd0, 0, 0, 5'd3,  0, 0, 32'h0,        32'h0,        0, 4'b0010, 32'hA5A5A5A5);
        tbl[3]  = mk(1, 32'h4002, 32'h0,        1, 0, 2'd2, 0, 1, 5'd4,  0, 0, 32'h0,        32'h4002,     1, 4'h0,    32'h0);
        tbl[4]  = mk(1, 32'h1234, 32'h0,        0, 0, 2'd2, 0, 1, 5'd5,  0, 0, 32'h0,        32'h1234,     0, 4'h0,    32'h0);
        tbl[5]  = mk(1, 32'h1008, 32'h0,        1, 0, 2'd2, 0, 1, 5'd6,  0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 4'h0,    32'h0);
        tbl[6]  = mk(1, 32'h0010, 32'h0,        1, 0, 2'd1, 0, 1, 5'd7,  1, 0, 32'h00008001, 32'hFFFF8001, 0, 4'h0,    32'h0);
        tbl[7]  = mk(1, 32'h0022, 32'h12345678, 0, 1, 2'd1, 0, 0, 5'd8,  1, 0, 32'h0,        32'h0,        0, 4'b1100, 32'h56785678);
        tbl[8]  = mk(1, 32'h0040, 32'hCAFEBABE, 0, 1, 2'd2, 0, 0, 5'd9,  2, 0, 32'h0,        32'h0,        0, 4'b1111, 32'hCAFEBABE);
        tbl[9]  = mk(1, 32'h0050, 32'h0,        1, 0, 2'd3, 0, 1, 5'd10, 0, 0, 32'h0,        32'h50,       1, 4'h0,    32'h0);
        tbl[10] = mk(1, 32'h0061, 32'h1,        0, 1, 2'd1, 0, 0, 5'd11, 0, 0, 32'h0,        32'h61,       1, 4'h0,    32'h0);
        tbl[11] = mk(1, 32'h1002, 32'h0,        1, 0, 2'd0, 1, 1, 5'd12, 0, 1, 32'h00F00000, 32'h000000F0, 0, 4'h0,    32'h0);
        tbl[12] = mk(1, 32'h0077, 32'h0,        0, 0, 2'd0, 0, 1, 5'd0,  0, 0, 32'h0,        32'h77,       0, 4'h0,    32'h0);
        tbl[13] = mk(0, 32'h0099, 32'h0,        1, 0, 2'd2, 0, 1, 5'd13, 0, 0, 32'h0,        32'h0,        0, 4'h0,    32'h0);
        tbl[14] = mk(1, 32'h5000, 32'h0,        1, 0, 2'd0, 0, 1, 5'd14, 0, 2, 32'h1234567F, 32'h0000007F, 0, 4'h0,    32'h0);

        // Reset held with a live aligned load presented: nothing may start.
        i_rst = 1'b1; i_valid = 1'b1; i_addr = 32'h100; i_store_data = 32'h0;
        i_is_load = 1'b1; i_is_store = 1'b0; i_size = 2'd2; i_unsigned = 1'b0;
        i_reg_write_en = 1'b1; i_dest_addr = 5'd1;
        i_dmem_ready = 1'b1; i_dmem_rvalid = 1'b0; i_dmem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset stall", 32'(o_stall), 32'd0);
        chk("reset req", 32'(o_dmem_req), 32'd0);
        chk("reset wb_valid", 32'(o_wb_valid), 32'd0);
        chk("reset wb_data", o_wb_data, 32'h0);
        chk("reset wb_misc", {25'h0, o_wb_reg_write_en, o_wb_trap, o_wb_dest_addr}, 32'h0);
        i_rst = 1'b0; i_valid = 1'b0; i_is_load = 1'b0; i_dmem_ready = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 15; i++) run_op(tbl[i], $sformatf("vec%0d", i));

        // Reset while waiting for a load response; the late response must be dropped.
        i_valid = 1'b1; i_addr = 32'h100; i_is_load = 1'b1; i_is_store = 1'b0;
        i_size = 2'd2; i_reg_write_en = 1'b1; i_dest_addr = 5'd14; i_dmem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rstwait pre_stall", 32'(o_stall), 32'd1);
        chk("rstwait pre_req", 32'(o_dmem_req), 32'd0);
        i_rst = 1'b1; #1;
        chk("rstwait stall", 32'(o_stall), 32'd0);
        chk("rstwait req", 32'(o_dmem_req), 32'd0);
        chk("rstwait mem_outs", o_dmem_addr | o_dmem_wdata | {28'h0, o_dmem_mask}, 32'h0);
        chk("rstwait wb", {o_wb_valid, o_wb_trap, o_wb_reg_write_en, o_wb_dest_addr, 24'h0} | o_wb_data, 32'h0);
        i_valid = 1'b0; i_is_load = 1'b0; i_dmem_ready = 1'b0;
        i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'h5555AAAA;
        @(negedge clk);
        i_rst = 1'b0;
        @(posedge clk); #1;
        chk("rstwait post_wb_valid", 32'(o_wb_valid), 32'd0);
        chk("rstwait post_stall", 32'(o_stall), 32'd0);
        chk("rstwait post_req", 32'(o_dmem_req), 32'd0);
        i_dmem_rvalid = 1'b0;
        @(posedge clk); #1;
        chk("rstwait post2_wb_valid", 32'(o_wb_valid), 32'd0);
        run_op(tbl[4], "after_rst_alu");
        run_op(tbl[5], "after_rst_load");

        for (int n = 0; n < 250; n++) begin
            int k;
            r.valid = ($urandom_range(0, 9) != 0);
            k = $urandom_range(0, 2);
            r.ld = (k == 1);
            r.st = (k == 2);
            r.size = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            r.addr = $urandom;
            if ($urandom_range(0, 9) < 7) begin
                if (r.size == 2'd1) r.addr[0] = 1'b0;
                if (r.size == 2'd2) r.addr[1:0] = 2'b00;
            end
            r.data = $urandom;
            r.rdata = $urandom;
            r.uns = 1'($urandom_range(0, 1));
            r.rwe = 1'($urandom_range(0, 1));
            r.dest = 5'($urandom);
            r.rd = $urandom_range(0, 2);
            r.rv = $urandom_range(0, 2);
            r = model(r);
            run_op(r, $sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end
endmodule
